// File: rtl/f1_pkg.sv
// Shared definitions for the F1_Light PRBS-7 generator/checker pair:
// checker state encoding, LFSR tap positions and the generator seed.
package f1_pkg;

   // Checker state: HUNT is the reset state.
   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } chk_state_t;

   // Polynomial x^7 + x^6 + 1: new bit = s[7] ^ s[6], shifted in at s[1].
   localparam int PRBS_TAP_HI = 7;
   localparam int PRBS_TAP_LO = 6;

   // Generator reset seed, s[7:1].
   localparam logic [7:1] PRBS_SEED = 7'b0000001;

   // Next bit predicted from a 7-bit history (s[1] is the most recent bit).
   function automatic logic prbs7_predict(input logic [7:1] s);
      return s[PRBS_TAP_HI] ^ s[PRBS_TAP_LO];
   endfunction

endpackage

// File: rtl/prbs_sat_counter.sv
// Saturating up-counter. clear wins over a plain hold, but a clear in the
// same cycle as an increment lands on 1 so that the event is not lost.
module prbs_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Count register: reset, clear(+inc), then saturating increment.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= {{(W-1){1'b0}}, inc};
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + {{(W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: rtl/prbs7_checker.sv
// Serial PRBS-7 checker. Self-synchronises to the received stream in HUNT,
// then free-runs its own generator in LOCKED and counts bit errors.
// Optional feature: define PRBS7_BITCNT_EN to add the bit_count port and
// its 32-bit wrapping counter of bits checked while locked.
// Handshake: bit_in is consumed on every clock where bit_valid is high,
// one bit per clock, no backpressure; all other cycles are ignored.
module prbs7_checker
   import f1_pkg::*;
#(
   parameter int LOCK_COUNT  = 16,
   parameter int WINDOW      = 64,
   parameter int LOSS_THRESH = 8,
   parameter int ERR_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bit_valid,
   input  logic             bit_in,
   input  logic             clear,
   output logic             locked,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_count
`ifdef PRBS7_BITCNT_EN
   ,
   output logic [31:0]      bit_count
`endif
);

   localparam logic [7:0] LOCK_LAST = 8'(LOCK_COUNT - 1);
   localparam logic [7:0] WIN_LAST  = 8'(WINDOW - 1);
   localparam logic [7:0] LOSS_LAST = 8'(LOSS_THRESH - 1);

   chk_state_t state, state_n;
   logic [7:1] r, r_n;
   logic [2:0] fill, fill_n;
   logic [7:0] match_cnt, match_n;
   logic [7:0] win_cnt, win_n;
   logic [7:0] win_err, win_err_n;
   logic       p;
   logic       err_hit;

   // Next-state and datapath decisions for one valid bit.
   always_comb begin
      state_n   = state;
      r_n       = r;
      fill_n    = fill;
      match_n   = match_cnt;
      win_n     = win_cnt;
      win_err_n = win_err;
      err_hit   = 1'b0;
      p         = prbs7_predict(r);
      if (bit_valid) begin
         if (state == HUNT) begin
            // Feed the history from the line until it is full, then demand
            // an unbroken run of correct predictions (never on all-zero).
            r_n = {r[6:1], bit_in};
            if (fill != 3'd7) begin
               fill_n = fill + 3'd1;
            end else if ((r != 7'd0) && (bit_in == p)) begin
               if (match_cnt == LOCK_LAST) begin
                  state_n   = LOCKED;
                  match_n   = 8'd0;
                  win_n     = 8'd0;
                  win_err_n = 8'd0;
               end else begin
                  match_n = match_cnt + 8'd1;
               end
            end else begin
               match_n = 8'd0;
            end
         end else begin
            // Free-run on our own prediction so line errors do not propagate.
            r_n     = {r[6:1], p};
            err_hit = (bit_in != p);
            if (err_hit && (win_err == LOSS_LAST)) begin
               state_n   = HUNT;
               fill_n    = 3'd0;
               match_n   = 8'd0;
               win_n     = 8'd0;
               win_err_n = 8'd0;
            end else if (win_cnt == WIN_LAST) begin
               win_n     = 8'd0;
               win_err_n = 8'd0;
            end else begin
               win_n     = win_cnt + 8'd1;
               win_err_n = win_err + {7'd0, err_hit};
            end
         end
      end
   end

   // State and history registers plus the registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= HUNT;
         r         <= 7'd0;
         fill      <= 3'd0;
         match_cnt <= 8'd0;
         win_cnt   <= 8'd0;
         win_err   <= 8'd0;
         locked    <= 1'b0;
         err_pulse <= 1'b0;
      end else begin
         state     <= state_n;
         r         <= r_n;
         fill      <= fill_n;
         match_cnt <= match_n;
         win_cnt   <= win_n;
         win_err   <= win_err_n;
         locked    <= (state_n == LOCKED);
         err_pulse <= err_hit;
      end
   end

   prbs_sat_counter #(
      .W(ERR_W)
   ) u_err_cnt (
      .clk  (clk),
      .rst  (rst),
      .clear(clear),
      .inc  (err_hit),
      .count(err_count)
   );

`ifdef PRBS7_BITCNT_EN
   logic bit_inc;
   assign bit_inc = bit_valid && (state == LOCKED);

   // Wrapping count of bits checked while locked; held in HUNT.
   always_ff @(posedge clk) begin
      if (rst) begin
         bit_count <= 32'd0;
      end else if (clear) begin
         bit_count <= {31'd0, bit_inc};
      end else if (bit_inc) begin
         bit_count <= bit_count + 32'd1;
      end
   end
`endif

endmodule

// File: doc/prbs7_checker.md
# prbs7_checker

Serial PRBS-7 checker, the receive end of the F1_Light 7-bit LFSR pattern generator (polynomial x^7 + x^6 + 1; new bit = s[7] ^ s[6], shifted in at s[1]). It self-synchronises to an incoming bit stream, declares lock, and then counts bit errors against a locally regenerated sequence. It sits on the debug/loopback path, so the generator output can be checked through the light-driver chain or an external loopback.

## Interface
- LOCK_COUNT, 16: number of consecutive correct predictions in HUNT required to declare lock (range 1..255).
- WINDOW, 64: length of the loss-of-lock monitoring window, in valid bits (range 2..255).
- LOSS_THRESH, 8: number of errors within one window that forces return to HUNT (range 1..WINDOW).
- ERR_W, 16: width of the error counter.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- bit_valid  in  1  qualifies bit_in; the block ignores all other cycles.
- bit_in  in  1  received serial bit.
- clear  in  1  synchronous clear of the statistics counters; has no effect on lock state.
- locked  out  1  high while in LOCKED.
- err_pulse  out  1  one-cycle strobe per detected error (LOCKED only).
- err_count  out  ERR_W  saturating error total.
- bit_count  out  32  valid bits checked while LOCKED; present only with PRBS7_BITCNT_EN.

## Operation
- State machine has two states: HUNT (reset state) and LOCKED.
- 7-bit register r holds the history. r[1] is the most recent bit. Predicted bit p = r[7] ^ r[6].
- HUNT:
  - Each valid bit shifts into r, so the register is fed from the received stream.
  - A fill counter (0..7) saturates at 7. No comparison is made until the counter reaches 7.
  - Once full, each valid bit is compared with p. A match increments match_cnt; a mismatch clears it.
  - If r == 0, the comparison counts as a mismatch. The block never locks on all-zero data.
  - When match_cnt reaches LOCK_COUNT, the state goes to LOCKED. The window counter and window error counter are cleared.
- LOCKED:
  - r advances with p, not with bit_in, so it behaves as a free-running generator and errors do not propagate.
  - bit_in != p produces err_pulse. err_count increments and saturates at all-ones. The window error counter increments.
  - The window counter counts valid bits 0..WINDOW-1 and wraps to 0. The window error counter resets at the wrap.
  - If the window error counter reaches LOSS_THRESH, the state goes to HUNT. fill, match_cnt, and the window counters are cleared. err_count is retained.
- When clear coincides with an error, err_count becomes 1 and bit_count becomes 1.
- No outputs are produced while bit_valid is low. All state holds.

## Timing
- All outputs are registered. Reset value of every output is 0. Reset also clears r, fill, match_cnt, the window counters, and the state (to HUNT).
- err_pulse is asserted in the cycle after the erroneous valid bit is sampled. err_count updates in the same cycle.
- locked rises in the cycle after the valid bit that completes the LOCK_COUNT-th match. From a clean stream, that is valid bit 7 + LOCK_COUNT.
- locked falls in the cycle after the valid bit that brings the window error count to LOSS_THRESH. That bit is itself counted as an error and pulses err_pulse.
- rst asserted mid-lock: the next cycle shows every output at 0 and the state in HUNT, regardless of bit_valid.
- Back-to-back valid bits are supported at one bit per clock with no stall.

## Configuration
- PRBS7_BITCNT_EN defined:
  - Adds the bit_count port and a 32-bit wrapping counter.
  - The counter increments on every valid bit in LOCKED.
  - It is cleared by rst and clear, and it is held in HUNT.
- PRBS7_BITCNT_EN undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Shared package f1_pkg holds:
  - the checker state enum (HUNT, LOCKED);
  - the PRBS-7 tap constants (7 and 6);
  - the generator reset seed, 7'b0000001, which the benches use to build expected streams.
- One sub-module is natural: prbs_sat_counter, a parameterised saturating counter with clear-and-increment priority. It is used for err_count.

## Test plan
- Clean stream: generator with seed 1, 300 bits continuous → locked rises after bit 23, err_count = 0, no err_pulse.
- Single error: after lock, invert bit 100 → exactly one err_pulse one cycle later, err_count = 1, locked stays high.
- All-zero input: 500 zero bits → locked stays 0 throughout.
- Loss of lock: after lock, invert 8 bits within one 64-bit window → locked falls the cycle after the 8th error, err_count = 8. Clean data then relocks within 7 + 16 bits.
- Gapped valid: clean stream with bit_valid toggling 1010… → lock after 23 valid bits, identical to the continuous case.
- Clear and reset: clear coincident with an error gives err_count = 1. rst mid-lock gives all outputs 0 on the next cycle. With PRBS7_BITCNT_EN defined, bit_count is 1 after a clear coincident with a valid bit.
